imm_dec_stage: RTL and testbench

- Registered, parametrised successor of the combinational immediate decoder.
- Sits between fetch and register-read. Accepts one instruction and its PC per handshake.
- Emits the XLEN-wide immediate, an immediate-type tag, rd/rs1/rs2, and an illegal flag one cycle later.
- Valid/ready on both sides, 2-entry skid buffer, synchronous flush for branch redirect.

---
 rtl/imm_dec_pkg.sv | 37 +++
 rtl/imm_dec_core.sv | 88 ++++++++
 rtl/imm_dec_stage.sv | 93 +++++++++
 tb/tb_imm_dec_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_dec_pkg.sv
// Shared types for the immediate decode stage.
// Optional Zicsr decode is enabled by defining IMM_DEC_ZICSR_EN.
package imm_dec_pkg;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U,
    IMM_SH,
    IMM_Z
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Width-independent part of a decoded entry
  typedef struct packed {
    imm_type_e  typ;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/imm_dec_core.sv
// Combinational RISC-V immediate decoder, XLEN 32 or 64.
// CSR immediates are decoded only when IMM_DEC_ZICSR_EN is defined.
module imm_dec_core
  import imm_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output dec_fields_t     dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [5:0] shamt;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign shamt = (XLEN == 64) ? instr[25:20]
                              : {1'b0, instr[24:20]};

  function automatic logic [XLEN-1:0] sext(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    imm         = '0;
    dec.typ     = IMM_NONE;
    dec.illegal = 1'b0;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    unique case (1'b1)
      op == OP_IMM: begin
        if (f3[1:0] == 2'b01) begin
          dec.typ = IMM_SH;
          imm     = XLEN'(shamt);
        end else begin
          dec.typ = IMM_I;
          imm     = sext({{20{instr[31]}}, instr[31:20]});
        end
      end
      op == OP_LOAD || op == OP_JALR: begin
        dec.typ = IMM_I;
        imm     = sext({{20{instr[31]}}, instr[31:20]});
      end
      op == OP_STORE: begin
        dec.typ = IMM_S;
        imm     = sext({{20{instr[31]}}, instr[31:25],
                        instr[11:7]});
      end
      op == OP_BRANCH: begin
        dec.typ = IMM_B;
        imm     = sext({{20{instr[31]}}, instr[7],
                        instr[30:25], instr[11:8], 1'b0});
      end
      op == OP_JAL: begin
        dec.typ = IMM_J;
        imm     = sext({{12{instr[31]}}, instr[19:12],
                        instr[20], instr[30:21], 1'b0});
      end
      op == OP_LUI || op == OP_AUIPC: begin
        dec.typ = IMM_U;
        imm     = sext({instr[31:12], 12'b0});
      end
      op == OP_OP || op == OP_FENCE: begin
        dec.typ = IMM_NONE;
      end
`ifdef IMM_DEC_ZICSR_EN
      op == OP_SYSTEM: begin
        if (f3[2]) begin
          dec.typ = IMM_Z;
          imm     = XLEN'(instr[19:15]);
        end else begin
          dec.typ = IMM_I;
          imm     = sext({{20{instr[31]}}, instr[31:20]});
        end
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_dec_stage.sv
// Registered immediate decode stage with 2-entry skid buffer and flush.
// Zicsr decode is enabled by defining IMM_DEC_ZICSR_EN.
module imm_dec_stage
  import imm_dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
    dec_fields_t     f;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  dec_fields_t     dec_f;
  entry_t          in_e;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_v;
  logic            skid_v;
  logic            acc;
  logic            drain;

  imm_dec_core #(
    .XLEN (XLEN)
  ) u_core (
    .instr (in_instr),
    .imm   (dec_imm),
    .dec   (dec_f)
  );

  assign in_e  = '{imm: dec_imm, pc: in_pc, f: dec_f};
  assign acc   = in_valid && in_ready;
  assign drain = out_v && out_ready;

  // Skid is only ever filled while the output is held, so
  // an occupied skid always refills the output before new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        out_q <= in_e;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= in_e;
      skid_v <= 1'b1;
    end
  end

  assign in_ready     = !skid_v;
  assign out_valid    = out_v;
  assign out_imm      = out_q.imm;
  assign out_imm_type = out_q.f.typ;
  assign out_rd       = out_q.f.rd;
  assign out_rs1      = out_q.f.rs1;
  assign out_rs2      = out_q.f.rs2;
  assign out_pc       = out_q.pc;
  assign out_illegal  = out_q.f.illegal;

endmodule

// File: tb/tb_imm_dec_stage.sv
// Scoreboard bench for imm_dec_stage at XLEN=32 and XLEN=64.
// Expected entries come from an arithmetic reference decoder.
module tb_imm_dec_stage;
  import imm_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, pc32;
  logic [2:0]  t32;
  logic [4:0]  rd32, rs132, rs232;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [31:0] pc64;
  logic [2:0]  t64;
  logic [4:0]  rd64, rs164, rs264;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  t;
    logic        il;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  imm_dec_stage #(.XLEN(32), .PC_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_imm_type(t32),
    .out_rd(rd32), .out_rs1(rs132), .out_rs2(rs232),
    .out_pc(pc32), .out_illegal(ill32)
  );

  imm_dec_stage #(.XLEN(64), .PC_W(32)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_imm_type(t64),
    .out_rd(rd64), .out_rs1(rs164), .out_rs2(rs264),
    .out_pc(pc64), .out_illegal(ill64)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Immediates rebuilt from signed arithmetic on the whole word
  function automatic void ref_dec(input logic [31:0] i, input int xl,
                                  output logic [63:0] imm,
                                  output logic [2:0] t,
                                  output logic il);
    longint s, z, r;
    s = longint'($signed(i));
    z = longint'(i);
    r = 0;
    t = IMM_NONE;
    il = 1'b0;
    case (i[6:0])
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          t = IMM_SH;
          r = (z >> 20) & ((xl == 64) ? 63 : 31);
        end else begin
          t = IMM_I;
          r = s >>> 20;
        end
      end
      7'h03, 7'h67: begin t = IMM_I; r = s >>> 20; end
      7'h23: begin
        t = IMM_S;
        r = ((s >>> 25) << 5) | ((z >> 7) & 31);
      end
      7'h63: begin
        t = IMM_B;
        r = ((s >>> 31) << 12) | (((z >> 7) & 1) << 11)
          | (((z >> 25) & 63) << 5) | (((z >> 8) & 15) << 1);
      end
      7'h6F: begin
        t = IMM_J;
        r = ((s >>> 31) << 20) | (((z >> 12) & 255) << 12)
          | (((z >> 20) & 1) << 11) | (((z >> 21) & 1023) << 1);
      end
      7'h37, 7'h17: begin t = IMM_U; r = s & ~longint'(4095); end
      7'h33, 7'h0F: t = IMM_NONE;
`ifdef IMM_DEC_ZICSR_EN
      7'h73: begin
        if (i[14]) begin t = IMM_Z; r = (z >> 15) & 31; end
        else begin t = IMM_I; r = s >>> 20; end
      end
`endif
      default: il = 1'b1;
    endcase
    imm = r;
    if (xl == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic exp_t mk(input logic [31:0] i,
                              input logic [31:0] pc);
    exp_t x;
    logic [63:0] v;
    logic [2:0] t;
    logic il;
    ref_dec(i, 32, v, t, il);
    x.e32 = v[31:0];
    ref_dec(i, 64, v, t, il);
    x.e64 = v;
    x.t = t;
    x.il = il;
    x.rd = i[11:7];
    x.rs1 = i[19:15];
    x.rs2 = i[24:20];
    x.pc = pc;
    return x;
  endfunction

  logic         stall_v = 1'b0;
  logic [127:0] stall_s;
  logic [127:0] snap;

  always @(negedge clk) begin
    snap = 128'({imm64, t64, ill64, rd64, rs164, rs264, pc64});
    if (rst || flush) begin
      q.delete();
      stall_v = 1'b0;
    end else begin
      if (stall_v) chk("stable", snap, stall_s);
      if (ov64 && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out", 128'(ov64), 128'(0));
        end else begin
          e = q.pop_front();
          chk("dec32", 128'({ov32, imm32, t32, ill32, rd32, rs132,
                             rs232, pc32}),
              128'({1'b1, e.e32, e.t, e.il, e.rd, e.rs1, e.rs2,
                    e.pc}));
          chk("dec64", snap,
              128'({e.e64, e.t, e.il, e.rd, e.rs1, e.rs2, e.pc}));
        end
      end
      stall_v = ov64 && !out_ready;
      stall_s = snap;
      if (in_valid && rdy64) q.push_back(mk(in_instr, in_pc));
    end
  end

  task automatic direct(input logic [31:0] ins, input logic [31:0] x32,
                        input logic [63:0] x64, input logic [2:0] t,
                        input logic il);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = ins; in_pc = $urandom;
    out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dir_valid", 128'({ov32, ov64}), 128'(2'b11));
    chk("dir32", 128'({imm32, t32, ill32}), 128'({x32, t, il}));
    chk("dir64", 128'({imm64, t64, ill64}), 128'({x64, t, il}));
  endtask

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc = $urandom;
  endtask

  logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                           7'h37, 7'h17, 7'h33, 7'h0F, 7'h73, 7'h7F,
                           7'h00};

  initial begin
    int base;
    logic [31:0] ins;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_instr = '0; in_pc = '0;
    #7;
    chk("reset_state", 128'({ov32, ov64, imm32, imm64, t32, t64,
                             rd32, pc64, ill64}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    chk("ready_after_reset", 128'({rdy32, rdy64}), 128'(2'b11));

    direct(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, IMM_I, 0);
    chk("addi_regs", 128'({rd32, rs132, rd64}), 128'({5'd1, 5'd0, 5'd1}));
    direct(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, IMM_B, 0);
    direct(32'h4030D093, 32'h3, 64'h3, IMM_SH, 0);
    direct(32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, IMM_U, 0);
    direct(32'h03F09093, 32'd31, 64'd63, IMM_SH, 0);
    direct(32'h00000000, 32'h0, 64'h0, IMM_NONE, 1);
`ifdef IMM_DEC_ZICSR_EN
    direct(32'h00105073, 32'h0, 64'h0, IMM_Z, 0);
`else
    direct(32'h00105073, 32'h0, 64'h0, IMM_NONE, 1);
`endif

    // Backpressure: A, B accepted, C refused until drain
    @(posedge clk); #1;
    base = n_out;
    out_ready = 1'b0;
    offer(32'h00100093);
    @(posedge clk); #1 offer(32'h00200113);
    @(posedge clk); #1 offer(32'h00300193);
    chk("bp_ready_low", 128'({rdy32, rdy64}), 128'(0));
    @(posedge clk); #1;
    chk("bp_hold", 128'({rdy64, ov64}), 128'(2'b01));
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("bp_count", 128'(n_out - base), 128'(3));

    // Flush with output and skid full plus an offered input
    base = n_out;
    out_ready = 1'b0;
    offer(32'h00400213);
    @(posedge clk); #1 offer(32'h00500293);
    @(posedge clk); #1 offer(32'h00600313);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", 128'({ov32, ov64, rdy32, rdy64}), 128'(4'b0011));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_count", 128'(n_out - base), 128'(0));

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    offer(32'hFFF00093);
    @(posedge clk); #1 offer(32'h800000B7);
    @(posedge clk); #1 in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("async_reset", 128'({ov32, ov64, imm32, imm64, t64, rd64,
                                 pc32, ill64}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    chk("ready_after_rst2", 128'({rdy64, ov64}), 128'(2'b10));

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[6:0] = ops[$urandom_range(12)];
      in_instr = ins;
      in_pc = $urandom;
      in_valid = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(99) < 3);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("drain_empty", 128'(q.size()), 128'(0));
    chk("drain_idle", 128'({ov64, rdy64}), 128'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
